// File: rtl/student_ss_gpio.sv
// student_ss_gpio: APB-mapped GPIO with per-pin direction, atomic set/clear,
// synchronised inputs and edge-triggered W1C interrupts.
// Optional build macro: STUDENT_SS_GPIO_LOOPBACK_EN (ss_ctrl_1[1] feeds
// pmod_gpo back into the input synchroniser instead of pmod_gpi).
module student_ss_gpio #(
  parameter int APB_AW      = 10,
  parameter int APB_DW      = 32,
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_int,
  input  logic [APB_AW-1:0]     PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_DW-1:0]     PWDATA,
  input  logic [APB_DW/8-1:0]   PSTRB,
  output logic [APB_DW-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  irq_en_1,
  input  logic [7:0]            ss_ctrl_1,
  output logic                  irq_1,
  input  logic [GPIO_W-1:0]     pmod_gpi,
  output logic [GPIO_W-1:0]     pmod_gpo,
  output logic [GPIO_W-1:0]     pmod_gpio_oe
);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_ready;
  logic                w_access;
  logic                w_err;
  logic                w_wr;
  logic [31:0]         w_addr;
  logic [2:0]          w_off;
  logic [APB_DW-1:0]   w_bmask;
  logic [GPIO_W-1:0]   w_m;
  logic [GPIO_W-1:0]   w_wdm;
  logic [GPIO_W-1:0]   w_rd_g;
  logic [APB_DW-1:0]   w_rdata;
  logic [APB_DW-1:0]   r_prdata;
  logic                r_slverr;

  logic [GPIO_W-1:0]   r_out;
  logic [GPIO_W-1:0]   r_dir;
  logic [GPIO_W-1:0]   r_rise_en;
  logic [GPIO_W-1:0]   r_fall_en;
  logic [GPIO_W-1:0]   r_status;
  logic [GPIO_W-1:0]   r_sync [SYNC_STAGES];
  logic [GPIO_W-1:0]   r_hist;
  logic [GPIO_W-1:0]   w_sync_in;
  logic [GPIO_W-1:0]   w_in;
  logic [GPIO_W-1:0]   w_evt;
  logic [GPIO_W-1:0]   w_w1c;
  logic                w_unused;

  // Byte-masked merge used by every plain read/write register.
  function automatic logic [GPIO_W-1:0] f_merge(input logic [GPIO_W-1:0] old_v,
                                                input logic [GPIO_W-1:0] data_m,
                                                input logic [GPIO_W-1:0] mask);
    return (old_v & ~mask) | data_m;
  endfunction

  // APB FSM state register.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // APB FSM next state: one wait state, then a single-cycle response.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: if (PSEL && PENABLE) w_state_nxt = S_RESP;
      S_RESP: begin
        w_ready     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_access = (r_state == S_IDLE) && PSEL && PENABLE;
  assign w_addr   = 32'(PADDR);
  assign w_off    = w_addr[4:2];
  assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr > 32'h1C) ||
                    (PWRITE && (w_off == 3'd2));
  assign w_wr     = w_access && PWRITE && !w_err;

  // Expand byte strobes into a bit mask.
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < APB_DW/8; b++) w_bmask[b*8 +: 8] = {8{PSTRB[b]}};
  end

  assign w_m   = w_bmask[GPIO_W-1:0];
  assign w_wdm = PWDATA[GPIO_W-1:0] & w_m;

  // Read mux; SET/CLR and unmapped bits read as zero.
  always_comb begin
    w_rd_g = '0;
    case (w_off)
      3'd0:    w_rd_g = r_out;
      3'd1:    w_rd_g = r_dir;
      3'd2:    w_rd_g = w_in;
      3'd3:    w_rd_g = r_rise_en;
      3'd4:    w_rd_g = r_fall_en;
      3'd5:    w_rd_g = r_status;
      default: w_rd_g = '0;
    endcase
    w_rdata = '0;
    w_rdata[GPIO_W-1:0] = w_rd_g;
  end

  // Response registers: loaded on access, cleared after the response cycle.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      r_prdata <= '0;
      r_slverr <= 1'b0;
    end else if (w_access) begin
      r_prdata <= (w_err || PWRITE) ? '0 : w_rdata;
      r_slverr <= w_err;
    end else if (r_state == S_RESP) begin
      r_prdata <= '0;
      r_slverr <= 1'b0;
    end
  end

  assign PREADY  = w_ready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_slverr;

  // Control registers written from the bus, including atomic SET/CLR on OUT.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (w_off)
        3'd0:    r_out     <= f_merge(r_out, w_wdm, w_m);
        3'd1:    r_dir     <= f_merge(r_dir, w_wdm, w_m);
        3'd3:    r_rise_en <= f_merge(r_rise_en, w_wdm, w_m);
        3'd4:    r_fall_en <= f_merge(r_fall_en, w_wdm, w_m);
        3'd6:    r_out     <= r_out | w_wdm;
        3'd7:    r_out     <= r_out & ~w_wdm;
        default: ;
      endcase
    end
  end

`ifdef STUDENT_SS_GPIO_LOOPBACK_EN
  assign w_sync_in = ss_ctrl_1[1] ? r_out : pmod_gpi;
`else
  assign w_sync_in = pmod_gpi;
`endif

  // Input synchroniser chain plus one-cycle history for edge detection.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= w_sync_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_in  = r_sync[SYNC_STAGES-1];
  assign w_evt = ((w_in & ~r_hist & r_rise_en) | (~w_in & r_hist & r_fall_en)) &
                 {GPIO_W{ss_ctrl_1[0]}};
  assign w_w1c = (w_wr && (w_off == 3'd5)) ? w_wdm : '0;

  // Sticky event status; a new event beats a same-cycle W1C.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) r_status <= '0;
    else           r_status <= (r_status & ~w_w1c) | w_evt;
  end

  assign irq_1        = irq_en_1 & (|r_status);
  assign pmod_gpo     = r_out;
  assign pmod_gpio_oe = r_dir & {GPIO_W{ss_ctrl_1[0]}};

  assign w_unused = &{1'b0, ss_ctrl_1[7:1], PWDATA, w_bmask};

endmodule

// File: doc/student_ss_gpio.md
# student_ss_gpio

Parametrised APB-mapped GPIO subsystem for a student area. It generalises the fixed-width PMOD GPIO example with several additions: configurable pin count, per-pin direction, atomic set/clear, input synchronisation, and edge-triggered interrupts with write-1-to-clear status. It sits on the subsystem APB bus and drives the off-chip PMOD pads and `irq_1`.

## Interface
Parameters:
- `APB_AW`, default 10: APB address width.
- `APB_DW`, default 32: APB data width; must be 32.
- `GPIO_W`, default 16: pin count; legal range 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth; minimum 2.

Ports:
- `clk_in`, in, 1: the single clock.
- `reset_int`, in, 1: reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- `PADDR`, in, `APB_AW`: byte address.
- `PSEL`, `PENABLE`, `PWRITE`, in, 1 each: APB control.
- `PWDATA`, in, 32: write data.
- `PSTRB`, in, 4: byte strobes.
- `PRDATA`, out, 32: read data.
- `PREADY`, `PSLVERR`, out, 1 each: response signals.
- `irq_en_1`, in, 1: global interrupt gate.
- `ss_ctrl_1`, in, 8: bit 0 = block enable; bit 1 = loopback (see Configuration); bits 7:2 ignored.
- `irq_1`, out, 1: level interrupt.
- `pmod_gpi`, in, `GPIO_W`: pad inputs.
- `pmod_gpo`, out, `GPIO_W`: pad outputs.
- `pmod_gpio_oe`, out, `GPIO_W`: 1 = pad driven.

## Operation
Register map (byte offsets; bits above `GPIO_W` read 0 and ignore writes):
- 0x00 OUT, rw: output data.
- 0x04 DIR, rw: 1 = output.
- 0x08 IN, ro: synchronised pin state.
- 0x0C RISE_EN, rw: rising-edge interrupt enable per pin.
- 0x10 FALL_EN, rw: falling-edge interrupt enable per pin.
- 0x14 STATUS, rw1c: latched edge events.
- 0x18 SET, wo: OUT |= wdata; reads 0.
- 0x1C CLR, wo: OUT &= ~wdata; reads 0.

Outputs and bus behaviour:
- `pmod_gpo = OUT`.
- `pmod_gpio_oe = DIR & {GPIO_W{ss_ctrl_1[0]}}`.
- `PSTRB` masks byte lanes on every writable register, including STATUS, SET and CLR.
- `PSLVERR=1` for: `PADDR[1:0]!=0`, offset > 0x1C, or a write to IN. Errored accesses have no side effect and `PRDATA` is 0.

APB FSM:
- IDLE: when `PSEL & PENABLE`, decode and perform the write, register read data, go to RESP.
- RESP: `PREADY=1` with `PSLVERR`/`PRDATA` valid for exactly one cycle, then back to IDLE unconditionally.
- Every transfer therefore has exactly one wait state.

Input path:
- `pmod_gpi` passes through `SYNC_STAGES` flops into IN.
- A history register holds IN from the previous cycle.
- rise = IN & ~hist & RISE_EN; fall = ~IN & hist & FALL_EN.
- Event bits OR into STATUS only when `ss_ctrl_1[0]=1`.
- `irq_1 = irq_en_1 & |STATUS`, combinational from STATUS.

Boundary rules:
- Event and W1C on the same bit in the same cycle: set wins, bit stays 1.
- Clearing RISE_EN or FALL_EN does not clear STATUS.
- With `ss_ctrl_1[0]=0`, registers remain accessible; outputs are tri-stated via oe; STATUS holds.

## Timing
- Reset values are all 0: OUT, DIR, RISE_EN, FALL_EN, STATUS, sync chain, history, `PRDATA`, `PREADY`, `PSLVERR`, `irq_1`, `pmod_gpo`, `pmod_gpio_oe`. FSM resets to IDLE.
- Reset mid-transfer: FSM returns to IDLE with `PREADY=0`. A write not yet performed (still in IDLE) is lost.
- Write effect: the register updates on the edge that leaves IDLE, so `pmod_gpo`/`pmod_gpio_oe` change while `PREADY=1`.
- Pin to IN: `SYNC_STAGES` edges.
- Pin to STATUS/`irq_1`: `SYNC_STAGES+1` edges.
- A pin held high through reset release produces a rising event `SYNC_STAGES+1` edges after release, if enabled.
- Edges shorter than one `clk_in` period are not guaranteed to be captured.

## Configuration
- `STUDENT_SS_GPIO_LOOPBACK_EN` defined: when `ss_ctrl_1[1]=1`, the synchroniser input is `pmod_gpo` instead of `pmod_gpi`. Pads and oe are unaffected.
- Undefined: `ss_ctrl_1[1]` is ignored and the mux is not built.

## Test plan
- Reset, then read every offset: all 0, `PSLVERR=0`, `PREADY` high for exactly one cycle per access.
- `ss_ctrl_1=1`; write DIR=0x00FF, OUT=0x1234; SET 0x0F00; CLR 0x0004: `pmod_gpio_oe=0x00FF`, `pmod_gpo=0x1F30`, OUT readback 0x1F30.
- RISE_EN=0x0100, `irq_en_1=1`; drive `pmod_gpi[8]` 0->1: STATUS=0x0100 and `irq_1=1` three edges later (`SYNC_STAGES=2`). W1C 0x0100 clears `irq_1`. A FALL event with FALL_EN=0 leaves STATUS at 0.
- Schedule a W1C of bit 8 on the same edge a new rising event on bit 8 latches: STATUS stays 0x0100.
- Write IN, read 0x20, read 0x02: each gives `PSLVERR=1` with no register change. Write OUT with `PSTRB=0b0010`, data 0xABCD: only bits 15:8 become 0xAB.
- With `STUDENT_SS_GPIO_LOOPBACK_EN`, `ss_ctrl_1=0x03`, OUT=0x00A5, `pmod_gpi=0`: IN reads 0x00A5 after two edges.
